// File: rtl/hpi_access_sequencer.sv
// Sequences HPI bus cycles for a CY7C67200 with programmable setup/strobe/hold/recovery
// timing, round-robin arbitration between two requesters, and the chip reset pulse.
module hpi_access_sequencer #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 2,
  parameter int unsigned RST_CYC      = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        sw_reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in,
  output logic        otg_hpi_reset_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_CHIPRST = 3'd0, S_IDLE = 3'd1, S_SETUP = 3'd2,
    S_STROBE  = 3'd3, S_HOLD = 3'd4, S_RECOVER = 3'd5
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] REC_LD    = 4'(RECOVERY_CYC - 1);
  localparam logic [7:0] RST_LD    = 8'(RST_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        gnt_q, gnt_d, last_q, last_d, wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rd_q, rd_d;
  logic        take_s, take_id_s;
  logic        cs_n_q, cs_n_d, r_n_q, r_n_d, w_n_q, w_n_d, oe_q, oe_d;
  logic        hpi_rst_n_q, hpi_rst_n_d, busy_q, busy_d;
  logic        rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [15:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
  logic        phase_on_s, rsp_s;

  // State, phase counters, latched request and registered pad/response outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= S_CHIPRST;
      cnt_q        <= 4'd0;
      rcnt_q       <= RST_LD;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= 2'd0;
      wdata_q      <= 16'h0000;
      rd_q         <= 16'h0000;
      cs_n_q       <= 1'b1;
      r_n_q        <= 1'b1;
      w_n_q        <= 1'b1;
      oe_q         <= 1'b0;
      hpi_rst_n_q  <= 1'b0;
      busy_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= 16'h0000;
      rsp1_rdata_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      gnt_q        <= gnt_d;
      last_q       <= last_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      cs_n_q       <= cs_n_d;
      r_n_q        <= r_n_d;
      w_n_q        <= w_n_d;
      oe_q         <= oe_d;
      hpi_rst_n_q  <= hpi_rst_n_d;
      busy_q       <= busy_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // Next-state logic: phase sequencing, arbitration and request latching.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    take_s    = 1'b0;
    take_id_s = 1'b0;
    case (state_q)
      S_CHIPRST: begin
        if (rcnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      S_IDLE: begin
        if (sw_reset) begin
          state_d = S_CHIPRST;
          rcnt_d  = RST_LD;
        end else if (req0_valid || req1_valid) begin
          take_s    = 1'b1;
          // On a tie the requester not served last wins; otherwise whoever is valid.
          take_id_s = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          gnt_d     = take_id_s;
          last_d    = take_id_s;
          wr_d      = take_id_s ? req1_write : req0_write;
          addr_d    = take_id_s ? req1_addr : req0_addr;
          if (wr_d) begin
            wdata_d = take_id_s ? req1_wdata : req0_wdata;
          end else begin
            wdata_d = wdata_q;
          end
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            rd_d = otg_hpi_data_in;
          end else begin
            rd_d = rd_q;
          end
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECOVER;
          cnt_d   = REC_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (sw_reset) begin
          state_d = S_CHIPRST;
          rcnt_d  = RST_LD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_CHIPRST;
        rcnt_d  = RST_LD;
      end
    endcase
  end

  // Output logic: pad/response values are computed from the next state so they register in step with it.
  always_comb begin
    phase_on_s   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d       = ~phase_on_s;
    r_n_d        = ~((state_d == S_STROBE) && !wr_d);
    w_n_d        = ~((state_d == S_STROBE) && wr_d);
    oe_d         = phase_on_s && wr_d;
    hpi_rst_n_d  = (state_d != S_CHIPRST);
    busy_d       = (state_d != S_IDLE);
    rsp_s        = (state_d == S_HOLD) && (cnt_d == 4'd0);
    rsp0_valid_d = rsp_s && !gnt_d;
    rsp1_valid_d = rsp_s && gnt_d;
    if (rsp0_valid_d && !wr_d) begin
      rsp0_rdata_d = rd_d;
    end else begin
      rsp0_rdata_d = rsp0_rdata_q;
    end
    if (rsp1_valid_d && !wr_d) begin
      rsp1_rdata_d = rd_d;
    end else begin
      rsp1_rdata_d = rsp1_rdata_q;
    end
    req0_ready = take_s && !take_id_s;
    req1_ready = take_s && take_id_s;
  end

  assign rsp0_valid       = rsp0_valid_q;
  assign rsp1_valid       = rsp1_valid_q;
  assign rsp0_rdata       = rsp0_rdata_q;
  assign rsp1_rdata       = rsp1_rdata_q;
  assign otg_hpi_address  = addr_q;
  assign otg_hpi_cs_n     = cs_n_q;
  assign otg_hpi_r_n      = r_n_q;
  assign otg_hpi_w_n      = w_n_q;
  assign otg_hpi_data_out = wdata_q;
  assign otg_hpi_data_oe  = oe_q;
  assign otg_hpi_reset_n  = hpi_rst_n_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Directed bench for hpi_access_sequencer: chip reset, single reads/writes, round-robin,
// sw_reset during an access and system reset during HOLD.
module tb_hpi_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, sw_reset;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata, rsp1_rdata;
  logic [1:0]  hpi_addr;
  logic        cs_n, r_n, w_n, oe, hpi_rst_n, busy;
  logic [15:0] data_out, data_in, pad_val;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_ready0, n_ready1, n_rsp0, n_rsp1, n_wlow, n_rlow, n_rstlow, n_grant;
  int t_ready0, t_ready1, t_rsp0, t_rsp1, t_rst;
  int tr[0:7];
  int glog[0:7];
  logic [15:0] d_rsp0, d_rsp1, w_data;
  logic [1:0]  w_addr;
  logic        w_oe_bad, r_oe_bad, strobe_bad, drop0, drop1;

  always #5 clk = ~clk;

  // Pad model: the chip drives pad_val while the read strobe is low.
  assign data_in = !r_n ? pad_val : 16'h0000;

  hpi_access_sequencer dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_reset(sw_reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata),
    .otg_hpi_address(hpi_addr), .otg_hpi_cs_n(cs_n), .otg_hpi_r_n(r_n),
    .otg_hpi_w_n(w_n), .otg_hpi_data_out(data_out), .otg_hpi_data_oe(oe),
    .otg_hpi_data_in(data_in), .otg_hpi_reset_n(hpi_rst_n), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_ready0 = 0; n_ready1 = 0; n_rsp0 = 0; n_rsp1 = 0; n_wlow = 0; n_rlow = 0;
    n_rstlow = 0; n_grant = 0; t_ready0 = -1; t_ready1 = -1; t_rsp0 = -1; t_rsp1 = -1;
    t_rst = -1; w_oe_bad = 1'b0; r_oe_bad = 1'b0; strobe_bad = 1'b0;
    w_addr = 2'd0; w_data = 16'h0000; d_rsp0 = 16'h0000; d_rsp1 = 16'h0000;
  endtask

  // Sample at the falling edge, then return 1 time unit after the next rising edge to drive inputs.
  task automatic step();
    logic saw0, saw1;
    @(negedge clk);
    cyc = cyc + 1;
    saw0 = req0_ready;
    saw1 = req1_ready;
    if (saw0 || saw1) begin
      if (n_grant < 8) begin
        glog[n_grant] = saw1 ? 1 : 0;
        tr[n_grant] = cyc;
      end
      n_grant = n_grant + 1;
    end
    if (saw0) begin n_ready0 = n_ready0 + 1; t_ready0 = cyc; end
    if (saw1) begin n_ready1 = n_ready1 + 1; t_ready1 = cyc; end
    if (rsp0_valid) begin n_rsp0 = n_rsp0 + 1; t_rsp0 = cyc; d_rsp0 = rsp0_rdata; end
    if (rsp1_valid) begin n_rsp1 = n_rsp1 + 1; t_rsp1 = cyc; d_rsp1 = rsp1_rdata; end
    if (!w_n) begin
      n_wlow = n_wlow + 1; w_addr = hpi_addr; w_data = data_out;
      if (!oe) w_oe_bad = 1'b1;
    end
    if (!r_n) begin
      n_rlow = n_rlow + 1;
      if (oe) r_oe_bad = 1'b1;
    end
    if ((!r_n && !w_n) || ((!r_n || !w_n) && cs_n)) strobe_bad = 1'b1;
    if (!hpi_rst_n) begin
      n_rstlow = n_rstlow + 1;
      if (t_rst < 0) t_rst = cyc;
    end
    @(posedge clk);
    #1;
    if (saw0 && drop0) req0_valid = 1'b0;
    if (saw1 && drop1) req1_valid = 1'b0;
  endtask

  int rel;

  initial begin
    rst_n = 1'b0; sw_reset = 1'b0; pad_val = 16'h0000;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 2'd0; req0_wdata = 16'h0000;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 16'h0000;
    drop0 = 1'b1; drop1 = 1'b1;
    clear_stats();
    for (int i = 0; i < 3; i++) step();

    // Reset values
    check_eq("rst_ctrl", {22'd0, cs_n, r_n, w_n, oe, busy, hpi_rst_n,
                          req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 32'b1110_1000_00);
    check_eq("rst_addr", {30'd0, hpi_addr}, 32'd0);
    check_eq("rst_dout", {16'd0, data_out}, 32'd0);
    check_eq("rst_rdata", {rsp0_rdata, rsp1_rdata}, 32'd0);

    // 1. chip reset pulse after release
    rst_n = 1'b1;
    clear_stats();
    cyc = 0;
    step();
    check_eq("chiprst_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    check_eq("chiprst_len", n_rstlow, 8);
    check_eq("chiprst_first", t_rst, 1);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_rst_n", {31'd0, hpi_rst_n}, 32'd1);

    // 2. requester 0 write
    clear_stats();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd2; req0_wdata = 16'h1234;
    for (int i = 0; i < 30 && n_rsp0 == 0; i++) step();
    check_eq("wr_rsp_cnt", n_rsp0, 1);
    check_eq("wr_latency", t_rsp0 - t_ready0, 6);
    check_eq("wr_wlow", n_wlow, 4);
    check_eq("wr_addr", {30'd0, w_addr}, 32'd2);
    check_eq("wr_data", {16'd0, w_data}, 32'h1234);
    check_eq("wr_oe", {31'd0, w_oe_bad}, 32'd0);
    check_eq("wr_rlow", n_rlow, 0);

    // 3. requester 1 read
    clear_stats();
    pad_val = 16'hBEEF;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 16'h0000;
    for (int i = 0; i < 30 && n_rsp1 == 0; i++) step();
    check_eq("rd_rsp_cnt", n_rsp1, 1);
    check_eq("rd_ready0", n_ready0, 0);
    check_eq("rd_latency", t_rsp1 - t_ready1, 6);
    check_eq("rd_data", {16'd0, d_rsp1}, 32'hBEEF);
    check_eq("rd_rlow", n_rlow, 4);
    check_eq("rd_oe", {31'd0, r_oe_bad}, 32'd0);
    check_eq("rd_wlow", n_wlow, 0);

    // 4. both requesters held valid: round-robin
    clear_stats();
    pad_val = 16'h7E57;
    drop0 = 1'b0; drop1 = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd3;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 2'd1; req1_wdata = 16'h5555;
    for (int i = 0; i < 80 && n_grant < 4; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drop0 = 1'b1; drop1 = 1'b1;
    for (int i = 0; i < 30 && (n_rsp0 < 2 || n_rsp1 < 2); i++) step();
    check_eq("rr_grants", n_grant, 4);
    check_eq("rr_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]}, 32'h00010001);
    check_eq("rr_gap1", tr[1] - tr[0], 9);
    check_eq("rr_gap2", tr[2] - tr[1], 9);
    check_eq("rr_gap3", tr[3] - tr[2], 9);
    check_eq("rr_rsp", {n_rsp0[15:0], n_rsp1[15:0]}, 32'h00020002);
    check_eq("rr_rd0", {16'd0, d_rsp0}, 32'h7E57);
    check_eq("rr_wr1_keep", {16'd0, rsp1_rdata}, 32'hBEEF);
    check_eq("rr_waddr", {14'd0, w_addr, w_data}, 32'h0001_5555);
    check_eq("strobe_rules", {31'd0, strobe_bad}, 32'd0);

    // 5. sw_reset raised mid-STROBE
    clear_stats();
    pad_val = 16'hC0DE;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd1; req0_wdata = 16'hABCD;
    for (int i = 0; i < 60 && n_ready1 == 0; i++) begin
      step();
      if (n_wlow == 2 && !req1_valid && n_ready1 == 0) begin
        sw_reset = 1'b1;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd2;
      end
      if (t_rst >= 0) sw_reset = 1'b0;
    end
    check_eq("swr_rsp", n_rsp0, 1);
    check_eq("swr_latency", t_rsp0 - t_ready0, 6);
    check_eq("swr_wlow", n_wlow, 4);
    check_eq("swr_rst_after", t_rst - t_rsp0, 3);
    check_eq("swr_rst_len", n_rstlow, 8);
    check_eq("swr_grant_after", t_ready1 - t_rst, 8);
    for (int i = 0; i < 30 && n_rsp1 == 0; i++) step();
    check_eq("swr_rd_data", {16'd0, d_rsp1}, 32'hC0DE);

    // 6. system reset during HOLD
    clear_stats();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd0; req0_wdata = 16'h0F0F;
    for (int i = 0; i < 30 && n_ready0 == 0; i++) step();
    for (int i = 0; i < 5; i++) step();
    check_eq("hold_cs", {30'd0, cs_n, rsp0_valid}, 32'b01);
    clear_stats();
    rst_n = 1'b0;
    #1;
    check_eq("abort_outs", {28'd0, cs_n, oe, rsp0_valid, hpi_rst_n}, 32'b1000);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd2;
    step();
    step();
    rst_n = 1'b1;
    rel = cyc + 1;
    for (int i = 0; i < 40 && n_ready0 == 0; i++) step();
    check_eq("abort_no_rsp", n_rsp0, 0);
    check_eq("abort_regrant", t_ready0 - rel, 8);
    for (int i = 0; i < 30 && n_rsp0 == 0; i++) step();
    check_eq("abort_rd_data", {16'd0, d_rsp0}, 32'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
